rle_stream_decompressor: RTL and testbench
==========================================

Name: rle_stream_decompressor

Overview:
- Streaming, parametrised run-length decoder for the IO path. Consumes run words (value bit + run count) over a valid/ready handshake.
- Packs the decoded bit stream MSB-first into OUT_W-bit words and writes them to the image buffer at incrementing addresses until IMG_BITS bits are produced.
- Replaces file-driven, one-shot, bit-serial decompression with a clocked engine that emits up to OUT_W bits per cycle. It also has defined completion, zero-run and overflow behaviour.

Parameters:
- RUN_W, 16: run word width; bit RUN_W-1 = run value, bits RUN_W-2:0 = run count.
- OUT_W, 16: packed output word width (power of 2).
- IMG_BITS, 16384: total decoded bits per image (multiple of OUT_W).
- ADDR_W, 10: output address width; must be >= clog2(IMG_BITS/OUT_W).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins decoding one image.
- run_valid  input  1  run_data is valid.
- run_data  input  RUN_W  run word: [RUN_W-1] = value, [RUN_W-2:0] = count.
- run_ready  output  1  block accepts run_data this cycle.
- wr_en  output  1  one-cycle write strobe to the image buffer.
- wr_addr  output  ADDR_W  word address, 0 .. IMG_BITS/OUT_W-1.
- wr_data  output  OUT_W  packed bits; the first decoded bit is in wr_data[OUT_W-1].
- busy  output  1  high from the start acceptance to completion.
- done  output  1  one-cycle pulse when the last word is written.
- overflow_err  output  1  sticky: the input described more than IMG_BITS bits.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; all outputs 0; internal run remainder, fill count, shift word, bit total and address cleared.
- FSM states: IDLE, LOAD, EMIT, FLUSH, DONE.
- IDLE: run_ready=0. On start=1 -> LOAD, clear overflow_err, address, fill and bit total; busy=1 from the next cycle.
- LOAD: run_ready=1. A transfer occurs when run_valid&&run_ready; latch value and count, then -> EMIT. Count 0 -> stay in LOAD; the word is consumed and produces no bits. No transfer -> hold; no writes.
- EMIT: run_ready=0. Each cycle, n = min(run remainder, OUT_W-fill, IMG_BITS-bit total). Shift n copies of value into the word MSB-first; fill += n; remainder -= n; bit total += n.
- Word completion: when fill reaches OUT_W, wr_en=1 for exactly the next cycle with wr_data = word and wr_addr = current address. Then address++ and fill=0.
- After emitting, if bit total == IMG_BITS -> FLUSH. Else if remainder == 0 -> LOAD. Else stay in EMIT.
- Truncation: if bit total reaches IMG_BITS while remainder > 0, set overflow_err; the excess bits are discarded.
- FLUSH: wait for the final wr_en, then -> DONE.
- DONE: done=1 for one cycle, busy=0, then -> IDLE. No further runs are accepted, so later run words see run_ready=0.
- Overflow from a later run: overflow_err is set only by truncation inside a run. An extra run word is never consumed.
- Throughput: at most one output word per cycle. There is one bubble cycle per run word (LOAD) and one extra cycle per word boundary crossed.
- start while busy is ignored.
- Incomplete input stream: the block waits indefinitely in LOAD. It never writes a partial word.
- Reset mid-operation aborts immediately. No further writes occur and a new start is required.
- Widths: the remainder register is RUN_W-1 bits, the bit total is clog2(IMG_BITS)+1 bits, and the address wraps never, because completion precedes wrap.

Test Plan:
Test parameters: RUN_W=16, OUT_W=16, IMG_BITS=64, ADDR_W=2.
1. start; runs 16'h8005, 16'h000B, 16'h0030 -> wr_data 16'hF800 @0, then 16'h0000 @1, @2 and @3. done pulses once; overflow_err=0.
2. Single run 16'h8040 -> four writes of 16'hFFFF at addresses 0..3 in order, then done. run_ready stays 0 afterwards while run_valid is held with 16'h8001.
3. Runs 16'h8000, 16'h0000, 16'h8040 -> each zero-count word is consumed with no wr_en; output is identical to scenario 2.
4. Runs 16'h003C, 16'h800A -> words 16'h0000 @0..2 and 16'h000F @3. overflow_err=1 sticky until the next start; done pulses.
5. Backpressure: run_valid toggled randomly in scenario 1 -> identical writes and order, and no wr_en while starved. A start pulsed mid-decode is ignored.
6. rst_n dropped asynchronously during EMIT of scenario 2 after address 1 -> all outputs 0 immediately. After release with no start: no writes; run_ready=0.

Source files
------------

// File: rtl/rle_stream_decompressor.sv
// Run-length decoder: consumes {value, count} run words and packs the decoded
// bit stream MSB-first into OUT_W-bit words written at incrementing addresses.
module rle_stream_decompressor #(
   parameter int RUN_W    = 16,
   parameter int OUT_W    = 16,
   parameter int IMG_BITS = 16384,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              run_valid,
   input  logic [RUN_W-1:0]  run_data,
   output logic              run_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [OUT_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic              overflow_err
);

   localparam int REM_W  = RUN_W - 1;
   localparam int FILL_W = $clog2(OUT_W) + 1;
   localparam int TOT_W  = $clog2(IMG_BITS) + 1;
   localparam int CMP_W  = (REM_W > TOT_W) ? REM_W : TOT_W;

   localparam logic [FILL_W-1:0] OUT_C = FILL_W'(OUT_W);
   localparam logic [TOT_W-1:0]  IMG_C = TOT_W'(IMG_BITS);

   typedef enum logic [2:0] {IDLE, LOAD, EMIT, FLUSH, DONE} state_t;

   typedef struct packed {
      logic             value;
      logic [REM_W-1:0] count;
   } run_t;

   state_t            state, state_nxt;
   run_t              run_in;
   logic              run_val;
   logic [REM_W-1:0]  rem;
   logic [FILL_W-1:0] fill;
   logic [TOT_W-1:0]  total;
   logic [OUT_W-1:0]  word;
   logic [ADDR_W-1:0] addr;

   logic              load_xfer;
   logic [FILL_W-1:0] space;
   logic [TOT_W-1:0]  left;
   logic [CMP_W-1:0]  rem_c, space_c, left_c, n_c;
   logic [FILL_W-1:0] n, fill_nxt;
   logic [TOT_W-1:0]  total_nxt;
   logic [REM_W-1:0]  rem_nxt;
   logic [OUT_W-1:0]  ones, word_nxt;
   logic              word_full, img_full;

   assign run_in    = run_t'(run_data);
   assign load_xfer = run_valid && (state == LOAD);

   // Bits emitted this cycle: bounded by the run, the word and the image.
   assign space   = OUT_C - fill;
   assign left    = IMG_C - total;
   assign rem_c   = CMP_W'(rem);
   assign space_c = CMP_W'(space);
   assign left_c  = CMP_W'(left);

   always_comb begin
      n_c = rem_c;
      if (space_c < n_c) n_c = space_c;
      if (left_c < n_c)  n_c = left_c;
   end

   assign n         = FILL_W'(n_c);
   assign fill_nxt  = fill + n;
   assign total_nxt = total + TOT_W'(n);
   assign rem_nxt   = rem - REM_W'(n);
   assign ones      = run_val ? ~({OUT_W{1'b1}} << n) : '0;
   assign word_nxt  = (word << n) | ones;
   assign word_full = (fill_nxt == OUT_C);
   assign img_full  = (total_nxt == IMG_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = LOAD;
         LOAD: begin
            run_ready = 1'b1;
            busy      = 1'b1;
            // Zero-count runs are swallowed without leaving LOAD.
            if (run_valid && run_in.count != '0) state_nxt = EMIT;
         end
         EMIT: begin
            busy = 1'b1;
            if (img_full)             state_nxt = FLUSH;
            else if (rem_nxt == '0)   state_nxt = LOAD;
         end
         FLUSH: begin
            busy = 1'b1;
            if (wr_en) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_val      <= 1'b0;
         rem          <= '0;
         fill         <= '0;
         total        <= '0;
         word         <= '0;
         addr         <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         overflow_err <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: if (start) begin
               overflow_err <= 1'b0;
               addr         <= '0;
               fill         <= '0;
               total        <= '0;
               word         <= '0;
            end
            LOAD: if (load_xfer) begin
               run_val <= run_in.value;
               rem     <= run_in.count;
            end
            EMIT: begin
               rem   <= rem_nxt;
               total <= total_nxt;
               word  <= word_nxt;
               if (word_full) begin
                  wr_en   <= 1'b1;
                  wr_data <= word_nxt;
                  wr_addr <= addr;
                  addr    <= addr + ADDR_W'(1);
                  fill    <= '0;
               end else begin
                  fill <= fill_nxt;
               end
               // Image filled with run bits still pending: the excess is dropped.
               if (img_full && rem_nxt != '0) overflow_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rle_stream_decompressor.sv
// Randomized bench for rle_stream_decompressor: a queue-based bit-stream model
// predicts every write, the done pulse, run consumption and overflow.
module tb_rle_stream_decompressor;
   localparam int RUN_W    = 16;
   localparam int OUT_W    = 16;
   localparam int IMG_BITS = 64;
   localparam int ADDR_W   = 2;
   localparam int NWORDS   = IMG_BITS / OUT_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              run_valid = 1'b0;
   logic [RUN_W-1:0]  run_data = '0;
   logic              run_ready, wr_en, busy, done, overflow_err;
   logic [ADDR_W-1:0] wr_addr;
   logic [OUT_W-1:0]  wr_data;

   int n_chk = 0;
   int n_fail = 0;

   logic [RUN_W-1:0]  runs_q[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [OUT_W-1:0]  exp_data[$];
   bit                exp_ovf;
   int                exp_used;
   bit                mon_en = 1'b0;
   bit                done_pend = 1'b0;

   always #5 clk = ~clk;

   rle_stream_decompressor #(
      .RUN_W(RUN_W), .OUT_W(OUT_W), .IMG_BITS(IMG_BITS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .run_valid(run_valid),
      .run_data(run_data), .run_ready(run_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
      .overflow_err(overflow_err)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   // Expand runs into a flat bit queue, stop consuming once the image is full.
   function automatic void build_model();
      bit               bits[$];
      logic [OUT_W-1:0] d;
      int               cnt;
      exp_addr.delete();
      exp_data.delete();
      exp_ovf  = 1'b0;
      exp_used = 0;
      for (int i = 0; i < runs_q.size() && bits.size() < IMG_BITS; i++) begin
         exp_used++;
         cnt = int'(runs_q[i][RUN_W-2:0]);
         for (int k = 0; k < cnt; k++)
            if (bits.size() < IMG_BITS) bits.push_back(runs_q[i][RUN_W-1]);
            else exp_ovf = 1'b1;
      end
      for (int w = 0; w < NWORDS && (w + 1) * OUT_W <= bits.size(); w++) begin
         d = '0;
         for (int b = 0; b < OUT_W; b++) d = {d[OUT_W-2:0], bits[w*OUT_W+b]};
         exp_addr.push_back(ADDR_W'(w));
         exp_data.push_back(d);
      end
   endfunction

   // Compare process: every write against the model, done exactly one cycle
   // after the final write.
   initial begin
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            done_pend = 1'b0;
         end else begin
            if (done || done_pend) begin
               check("done_pulse", done, done_pend);
               if (done) check("busy_at_done", busy, 1'b0);
            end
            done_pend = 1'b0;
            if (wr_en) begin
               if (exp_data.size() == 0) begin
                  check("unexpected_write", 1'b1, 1'b0);
               end else begin
                  check("wr_addr", wr_addr, exp_addr[0]);
                  check("wr_data", wr_data, exp_data[0]);
                  void'(exp_addr.pop_front());
                  void'(exp_data.pop_front());
                  if (exp_data.size() == 0) done_pend = 1'b1;
               end
            end
         end
      end
   end

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("ovf_cleared_by_start", overflow_err, 1'b0);
   endtask

   task automatic run_image(input int pct, input bit mid_start);
      int idx, cyc;
      bit fire, got_done;
      build_model();
      mon_en = 1'b1;
      do_start();
      idx = 0; cyc = 0; got_done = 1'b0;
      while (!got_done && cyc < 3000) begin
         if (idx < runs_q.size()) begin
            run_valid = ($urandom_range(0, 99) < pct);
            run_data  = runs_q[idx];
         end else begin
            run_valid = 1'b0;
         end
         start = mid_start && (cyc == 4);
         @(negedge clk);
         fire = run_valid && run_ready;
         if (done) got_done = 1'b1;
         @(posedge clk); #1;
         if (fire) idx++;
         cyc++;
      end
      start = 1'b0;
      check("done_seen", got_done, 1'b1);
      // Leftover run words stay offered; none may be taken.
      for (int k = 0; k < 4; k++) begin
         run_valid = (idx < runs_q.size());
         if (run_valid) run_data = runs_q[idx];
         @(negedge clk);
         fire = run_valid && run_ready;
         check("run_ready_after_done", run_ready, 1'b0);
         check("ovf_sticky", overflow_err, exp_ovf);
         @(posedge clk); #1;
         if (fire) idx++;
      end
      run_valid = 1'b0;
      check("runs_consumed", idx, exp_used);
      check("writes_missing", exp_data.size(), 0);
      check("busy_idle", busy, 1'b0);
   endtask

   task automatic gen_random();
      int               tot, sel, c;
      logic [RUN_W-1:0] w;
      runs_q.delete();
      tot = 0;
      while (tot < IMG_BITS) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)     c = 0;
         else if (sel < 7) c = $urandom_range(1, 20);
         else              c = $urandom_range(1, 80);
         w = '0;
         w[RUN_W-1]   = 1'($urandom_range(0, 1));
         w[RUN_W-2:0] = (RUN_W-1)'(c);
         runs_q.push_back(w);
         tot += c;
      end
      if ($urandom_range(0, 1) == 1) runs_q.push_back(RUN_W'($urandom));
   endtask

   initial begin
      bit found;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_wr_addr", wr_addr, '0);
      check("rst_wr_data", wr_data, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovf", overflow_err, 1'b0);
      check("rst_run_ready", run_ready, 1'b0);
      rst_n = 1'b1;

      // Pin the model against hand-derived images
      runs_q = '{16'h8005, 16'h000B, 16'h0030};
      build_model();
      check("model_s1_w0", exp_data[0], 16'hF800);
      check("model_s1_w3", exp_data[3], 16'h0000);
      check("model_s1_ovf", exp_ovf, 1'b0);
      runs_q = '{16'h003C, 16'h800A};
      build_model();
      check("model_s4_w3", exp_data[3], 16'h000F);
      check("model_s4_ovf", exp_ovf, 1'b1);

      // Directed images
      runs_q = '{16'h8005, 16'h000B, 16'h0030};
      run_image(100, 1'b0);
      runs_q = '{16'h8040, 16'h8001};
      run_image(100, 1'b0);
      runs_q = '{16'h8000, 16'h0000, 16'h8040};
      run_image(100, 1'b0);
      runs_q = '{16'h003C, 16'h800A};
      run_image(100, 1'b0);
      runs_q = '{16'h8005, 16'h000B, 16'h0030};
      run_image(40, 1'b1);

      // Random images
      for (int t = 0; t < 30; t++) begin
         gen_random();
         run_image($urandom_range(30, 100), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of emission
      mon_en = 1'b0;
      do_start();
      run_valid = 1'b1;
      run_data  = 16'h8040;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         if (wr_en && wr_addr == ADDR_W'(1)) found = 1'b1;
      end
      check("reset_point_reached", found, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_wr_en", wr_en, 1'b0);
      check("arst_wr_addr", wr_addr, '0);
      check("arst_wr_data", wr_data, '0);
      check("arst_busy", busy, 1'b0);
      check("arst_run_ready", run_ready, 1'b0);
      check("arst_ovf", overflow_err, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("post_rst_no_write", wr_en, 1'b0);
         check("post_rst_no_ready", run_ready, 1'b0);
      end
      run_valid = 1'b0;

      // Recovery after a fresh start
      runs_q = '{16'h8005, 16'h000B, 16'h0030};
      run_image(70, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
